lr_car_detector: RTL and testbench

- Upstream stage of the highway/local-road traffic light controller; produces the `lr_has_car` request that controller consumes.
- Conditions two raw local-road loop sensors: arrival loop and stop-line departure loop.
- Keeps a saturating count of waiting cars, decremented only when a car departs on local-road green.
- Exposes the count and error/overflow status for debug LEDs.

---
 rtl/traffic_pkg.sv | 14 +
 rtl/lr_car_detector_sync_debounce.sv | 53 +++++
 rtl/lr_car_detector.sv | 67 ++++++
 tb/tb_lr_car_detector.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings for the local-road / highway traffic light chain.
package traffic_pkg;

   // Local-road light, one-hot as driven by the controller
   localparam logic [2:0] RED = 3'b001;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRE = 3'b100;

   // True only for an exact green code; non-one-hot values are not green
   function automatic logic is_green(input logic [2:0] light);
      return light == GRE;
   endfunction

endpackage

// File: rtl/lr_car_detector_sync_debounce.sv
// Two-flop synchronizer, stability filter and rising-edge event for one loop sensor.
module sync_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise_ev
);

   localparam int DC_W = $clog2(DEB_CYCLES) + 1;
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYCLES - 1);

   logic            s1, s2;
   logic [DC_W-1:0] dc;
   logic            filt, filt_d;

   // Bring the asynchronous loop level into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Accept a new level only after it has differed from filt for DEB_CYCLES samples
   always_ff @(posedge clk) begin
      if (rst) begin
         dc     <= '0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
      end else begin
         filt_d <= filt;
         if (s2 == filt) begin
            dc <= '0;
         end else if (dc == DC_LAST) begin
            filt <= s2;
            dc   <= '0;
         end else begin
            dc <= dc + DC_W'(1);
         end
      end
   end

   assign level   = filt;
   // One cycle per filtered rising edge; a held car gives a single event
   assign rise_ev = filt & ~filt_d;

endmodule

// File: rtl/lr_car_detector.sv
// Local-road car detector: conditions the two loop sensors and keeps a
// saturating count of waiting cars that drives the controller request.
module lr_car_detector
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int MAX_CARS   = 15,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arrive_raw,
   input  logic             depart_raw,
   input  logic [2:0]       lr_light,
   output logic             lr_has_car,
   output logic [CNT_W-1:0] car_count,
   output logic             overflow,
   output logic             depart_err
);

   localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_CARS);

   logic       arr_ev, dep_ev, dep_ok;
   // Filtered sensor levels, kept visible for debug probing only
   logic [1:0] unused_level;

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arrive (
      .clk     (clk),
      .rst     (rst),
      .raw     (arrive_raw),
      .level   (unused_level[0]),
      .rise_ev (arr_ev)
   );

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_depart (
      .clk     (clk),
      .rst     (rst),
      .raw     (depart_raw),
      .level   (unused_level[1]),
      .rise_ev (dep_ev)
   );

   // A departure only counts on green with someone actually queued
   assign dep_ok = dep_ev & is_green(lr_light) & (car_count != '0);

   // Queue counter and status flags; count saturates at both ends
   always_ff @(posedge clk) begin
      if (rst) begin
         car_count  <= '0;
         overflow   <= 1'b0;
         depart_err <= 1'b0;
      end else begin
         depart_err <= dep_ev & ~dep_ok;
         if (arr_ev && dep_ok) begin
            car_count <= car_count;
         end else if (arr_ev) begin
            if (car_count == MAX_Q) overflow  <= 1'b1;
            else                    car_count <= car_count + CNT_W'(1);
         end else if (dep_ok) begin
            car_count <= car_count - CNT_W'(1);
         end
      end
   end

   assign lr_has_car = (car_count != '0);

endmodule

// File: tb/tb_lr_car_detector.sv
// Self-checking bench for lr_car_detector: scenario table, hand sequences and
// randomized traffic checked against a window-based behavioural model.
module tb_lr_car_detector;
   import traffic_pkg::*;

   localparam int D    = 4;
   localparam int MAXC = 15;
   localparam int CW   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arrive_raw = 1'b0;
   logic          depart_raw = 1'b0;
   logic [2:0]    lr_light = RED;
   logic          lr_has_car;
   logic [CW-1:0] car_count;
   logic          overflow;
   logic          depart_err;

   int checks = 0;
   int errors = 0;

   lr_car_detector #(.DEB_CYCLES(D), .MAX_CARS(MAXC), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .arrive_raw (arrive_raw),
      .depart_raw (depart_raw),
      .lr_light   (lr_light),
      .lr_has_car (lr_has_car),
      .car_count  (car_count),
      .overflow   (overflow),
      .depart_err (depart_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Sensor i (0 = arrive, 1 = depart): raw seen two edges late; the filtered
   // level flips once the last D synchronized samples all disagree with it.
   bit sync_q [2][2];
   bit win    [2][D];
   int nsamp  [2];
   bit mfilt  [2];
   bit mpend  [2];
   int mcnt;
   bit movf, mderr;

   task automatic model_edge(input bit r, input bit a, input bit d, input logic [2:0] l);
      bit ok, all_diff;
      bit rawv [2];
      rawv[0] = a;
      rawv[1] = d;
      if (r) begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i][0] = 0; sync_q[i][1] = 0;
            nsamp[i] = 0; mfilt[i] = 0; mpend[i] = 0;
         end
         mcnt = 0; movf = 0; mderr = 0;
      end else begin
         ok    = mpend[1] && (l == 3'b100) && (mcnt != 0);
         mderr = mpend[1] && !ok;
         if (mpend[0] && ok) begin
         end else if (mpend[0]) begin
            if (mcnt == MAXC) movf = 1;
            else mcnt++;
         end else if (ok) begin
            mcnt--;
         end
         for (int i = 0; i < 2; i++) begin
            for (int k = D - 1; k > 0; k--) win[i][k] = win[i][k-1];
            win[i][0] = sync_q[i][1];
            if (nsamp[i] < D) nsamp[i]++;
            all_diff = (nsamp[i] == D);
            for (int k = 0; k < D; k++) if (win[i][k] == mfilt[i]) all_diff = 0;
            mpend[i] = 0;
            if (all_diff) begin
               mfilt[i] = !mfilt[i];
               mpend[i] = mfilt[i];
            end
            sync_q[i][1] = sync_q[i][0];
            sync_q[i][0] = rawv[i];
         end
      end
   endtask

   // One clock: drive, clock, advance model, compare all outputs
   task automatic step(input bit r, input bit a, input bit d, input logic [2:0] l);
      rst = r; arrive_raw = a; depart_raw = d; lr_light = l;
      @(posedge clk);
      model_edge(r, a, d, l);
      #1;
      checks++;
      if (car_count !== CW'(mcnt)) begin
         errors++; $display("FAIL model_cnt t=%0t got %0d want %0d", $time, car_count, mcnt);
      end
      checks++;
      if (lr_has_car !== (mcnt != 0)) begin
         errors++; $display("FAIL model_has t=%0t got %b want %b", $time, lr_has_car, mcnt != 0);
      end
      checks++;
      if (overflow !== movf) begin
         errors++; $display("FAIL model_ovf t=%0t got %b want %b", $time, overflow, movf);
      end
      checks++;
      if (depart_err !== mderr) begin
         errors++; $display("FAIL model_derr t=%0t got %b want %b", $time, depart_err, mderr);
      end
   endtask

   // ---------------- scenario table ----------------
   typedef struct {
      int         n;
      bit         r, a, d;
      logic [2:0] l;
      int         cnt;
      bit         ovf;
      int         errs;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int n, bit r, bit a, bit d, logic [2:0] l, int cnt, bit ovf, int errs);
      vec_t v;
      v.n = n; v.r = r; v.a = a; v.d = d; v.l = l; v.cnt = cnt; v.ovf = ovf; v.errs = errs;
      return v;
   endfunction

   initial begin
      int seen;
      bit lvl [2];
      int dur [2];
      logic [2:0] lt;
      int rv;

      // Reset and idle
      tbl.push_back(mk(2,  1, 0, 0, RED, 0, 0, 0));
      tbl.push_back(mk(20, 0, 0, 0, RED, 0, 0, 0));
      // Glitch rejection, then a minimum-length pulse
      tbl.push_back(mk(3,  0, 1, 0, RED, 0, 0, 0));
      tbl.push_back(mk(10, 0, 0, 0, RED, 0, 0, 0));
      tbl.push_back(mk(4,  0, 1, 0, RED, 0, 0, 0));
      tbl.push_back(mk(10, 0, 0, 0, RED, 1, 0, 0));
      tbl.push_back(mk(8,  0, 1, 0, RED, 2, 0, 0));
      tbl.push_back(mk(8,  0, 0, 0, RED, 2, 0, 0));
      // Departure gating
      tbl.push_back(mk(8,  0, 0, 1, RED, 2, 0, 1));
      tbl.push_back(mk(8,  0, 0, 0, RED, 2, 0, 0));
      tbl.push_back(mk(8,  0, 0, 1, YEL, 2, 0, 1));
      tbl.push_back(mk(8,  0, 0, 0, YEL, 2, 0, 0));
      tbl.push_back(mk(8,  0, 0, 1, GRE, 1, 0, 0));
      tbl.push_back(mk(8,  0, 0, 0, GRE, 1, 0, 0));
      tbl.push_back(mk(8,  0, 0, 1, 3'b110, 1, 0, 1));
      tbl.push_back(mk(8,  0, 0, 0, GRE, 1, 0, 0));
      tbl.push_back(mk(8,  0, 0, 1, GRE, 0, 0, 0));
      tbl.push_back(mk(8,  0, 0, 0, GRE, 0, 0, 0));
      tbl.push_back(mk(8,  0, 0, 1, GRE, 0, 0, 1));
      tbl.push_back(mk(8,  0, 0, 0, GRE, 0, 0, 0));
      // Saturation: 16 arrivals from empty
      for (int k = 1; k <= 16; k++) begin
         tbl.push_back(mk(8, 0, 1, 0, GRE, (k > MAXC) ? MAXC : k, k > MAXC, 0));
         tbl.push_back(mk(8, 0, 0, 0, GRE, (k > MAXC) ? MAXC : k, k > MAXC, 0));
      end
      // Simultaneous arrive + depart on green at full queue is net zero
      tbl.push_back(mk(8,  0, 1, 1, GRE, MAXC, 1, 0));
      tbl.push_back(mk(8,  0, 0, 0, GRE, MAXC, 1, 0));
      // Departure on green from full frees one slot
      tbl.push_back(mk(8,  0, 0, 1, GRE, MAXC - 1, 1, 0));
      tbl.push_back(mk(8,  0, 0, 0, GRE, MAXC - 1, 1, 0));
      // Reset mid-debounce with three queued and an arrival in flight
      tbl.push_back(mk(2,  1, 0, 0, RED, 0, 0, 0));
      for (int k = 1; k <= 3; k++) begin
         tbl.push_back(mk(8, 0, 1, 0, RED, k, 0, 0));
         tbl.push_back(mk(8, 0, 0, 0, RED, k, 0, 0));
      end
      tbl.push_back(mk(4,  0, 1, 0, RED, 3, 0, 0));
      tbl.push_back(mk(2,  1, 0, 0, RED, 0, 0, 0));
      tbl.push_back(mk(12, 0, 0, 0, RED, 0, 0, 0));

      model_edge(1, 0, 0, RED);

      foreach (tbl[i]) begin
         seen = 0;
         repeat (tbl[i].n) begin
            step(tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].l);
            if (depart_err === 1'b1) seen++;
         end
         checks++;
         if (car_count !== CW'(tbl[i].cnt)) begin
            errors++; $display("FAIL row%0d_cnt got %0d want %0d", i, car_count, tbl[i].cnt);
         end
         checks++;
         if (lr_has_car !== (tbl[i].cnt != 0)) begin
            errors++; $display("FAIL row%0d_has got %b want %b", i, lr_has_car, tbl[i].cnt != 0);
         end
         checks++;
         if (overflow !== tbl[i].ovf) begin
            errors++; $display("FAIL row%0d_ovf got %b want %b", i, overflow, tbl[i].ovf);
         end
         checks++;
         if (seen != tbl[i].errs) begin
            errors++; $display("FAIL row%0d_derr_pulses got %0d want %0d", i, seen, tbl[i].errs);
         end
      end

      // Single arrival latency: count appears exactly at edge 7 and holds
      step(1, 0, 0, RED);
      step(1, 0, 0, RED);
      for (int e = 1; e <= 12; e++) begin
         step(0, 1, 0, RED);
         checks++;
         if (car_count !== CW'((e >= 7) ? 1 : 0)) begin
            errors++; $display("FAIL latency_edge%0d got %0d want %0d", e, car_count, (e >= 7) ? 1 : 0);
         end
      end

      // Randomized traffic against the model
      lvl[0] = 0; lvl[1] = 0; dur[0] = 5; dur[1] = 9;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (dur[i] == 0) begin
               lvl[i] = !lvl[i];
               dur[i] = ($urandom_range(0, 9) < 7) ? $urandom_range(5, 14) : $urandom_range(1, 3);
            end
            dur[i]--;
         end
         rv = $urandom_range(0, 9);
         lt = (rv < 5) ? GRE : (rv < 7) ? RED : (rv < 9) ? YEL : 3'b101;
         step($urandom_range(0, 499) == 0, lvl[0], lvl[1], lt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
